// File: rtl/usc_rv_fetch_f2_if.sv
// Fetch F2 bus bundles: the I-cache response channel into F2, and the
// fetch-to-decode instruction bundle that F2 produces.

interface usc_rv_fetch_f2_rsp_if #(
  parameter int PC_W = 32
);
  logic            rsp_vld;
  logic            rsp_rdy;
  logic [63:0]     rsp_data;
  logic [PC_W-1:0] rsp_pc;
  logic [1:0]      rsp_pred;
  logic            rsp_fault;
  logic            rsp_page_fault;

  // master: I-cache side; slave: the F2 stage
  modport master (
    output rsp_vld, rsp_data, rsp_pc, rsp_pred, rsp_fault, rsp_page_fault,
    input  rsp_rdy
  );
  modport slave (
    input  rsp_vld, rsp_data, rsp_pc, rsp_pred, rsp_fault, rsp_page_fault,
    output rsp_rdy
  );
endinterface

interface usc_rv_fetch_f2_inst_if #(
  parameter int PC_W = 32
);
  logic [1:0]       inst_vld_f2;
  logic [1:0]       inst_rdy_f2;
  logic [1:0][31:0] inst_data_f2;
  logic [3:0]       inst_info_f2;
  logic [PC_W-1:0]  inst_pc_f2;

  // master: the F2 stage (producer); slave: decode
  modport master (
    output inst_vld_f2, inst_data_f2, inst_info_f2, inst_pc_f2,
    input  inst_rdy_f2
  );
  modport slave (
    input  inst_vld_f2, inst_data_f2, inst_info_f2, inst_pc_f2,
    output inst_rdy_f2
  );
endinterface

// File: rtl/usc_rv_fetch_f2.sv
// F2 fetch output stage: buffers 64-bit I-cache responses and hands up to two
// in-order instruction slots per cycle to decode. Optional macro USC_RV_FETCH_BYPASS_EN.

module usc_rv_fetch_f2 #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   core_flush,
  usc_rv_fetch_f2_rsp_if.slave   rsp,
  usc_rv_fetch_f2_inst_if.master inst
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [63:0]     data;
    logic [PC_W-1:0] pc;
    logic [1:0]      pred;
    logic [1:0]      mask;
    logic            fault;
    logic            page_fault;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          offset;

  entry_t        rsp_entry;
  entry_t        head;
  logic          bypass;
  logic          have_head;
  logic [1:0]    eff_mask;
  logic          slot0_idx;
  logic [1:0]    vld;
  logic [1:0]    rdy;
  logic          take0;
  logic          take1;
  logic          full_consume;
  logic          partial;
  logic          push;
  logic          pop;
  logic          fifo_empty;

  assign fifo_empty  = (count == '0);
  assign rsp.rsp_rdy = (count < FULL_CNT);

  // Turn a raw response into a stored entry: word-valid mask, taken
  // truncation, and faults collapsed to a single zero word in slot 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rsp_entry            = '0;
    rsp_entry.pc         = rsp.rsp_pc;
    rsp_entry.fault      = rsp.rsp_fault;
    rsp_entry.page_fault = rsp.rsp_page_fault;
    if (rsp.rsp_fault | rsp.rsp_page_fault) begin
      rsp_entry.data = '0;
      rsp_entry.mask = 2'b01;
      rsp_entry.pred = 2'b00;
    end else begin
      rsp_entry.data = rsp.rsp_data;
      rsp_entry.mask = {1'b1, ~rsp.rsp_pc[2]};
      if (~rsp.rsp_pc[2] & rsp.rsp_pred[0]) begin
        rsp_entry.mask[1] = 1'b0;
      end
      rsp_entry.pred = rsp.rsp_pred & rsp_entry.mask;
    end
  end

`ifdef USC_RV_FETCH_BYPASS_EN
  assign bypass = fifo_empty & ~core_flush & rsp.rsp_vld;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    head = mem[rd_ptr];
    if (bypass) begin
      head = rsp_entry;
    end
  end

  // Offset hides word0 once it has been consumed on its own.
  assign have_head = ~fifo_empty | bypass;
  assign eff_mask  = head.mask & {1'b1, ~offset};
  assign slot0_idx = ~eff_mask[0];
  assign vld[0]    = have_head & (eff_mask != 2'b00);
  assign vld[1]    = have_head & eff_mask[0] & eff_mask[1];

  always_comb begin
    inst.inst_vld_f2  = vld;
    inst.inst_data_f2 = '0;
    inst.inst_info_f2 = '0;
    inst.inst_pc_f2   = '0;
    if (vld[0]) begin
      inst.inst_data_f2[0] = slot0_idx ? head.data[63:32] : head.data[31:0];
      inst.inst_pc_f2      = head.pc;
      inst.inst_pc_f2[2]   = slot0_idx;
      inst.inst_info_f2    = {vld[1] & head.pred[1],
                              slot0_idx ? head.pred[1] : head.pred[0],
                              head.fault, head.page_fault};
    end
    if (vld[1]) begin
      inst.inst_data_f2[1] = head.data[63:32];
    end
  end

  // Slot 1 is only taken together with slot 0.
  assign rdy          = inst.inst_rdy_f2;
  assign take0        = vld[0] & rdy[0];
  assign take1        = vld[1] & rdy[1] & rdy[0];
  assign full_consume = vld[1] ? (take0 & take1) : take0;
  assign partial      = vld[1] & take0 & ~take1;

  // A bypassed response that is fully consumed never needs a FIFO slot.
  assign push = rsp.rsp_vld & rsp.rsp_rdy & ~core_flush & ~(bypass & full_consume);
  assign pop  = full_consume & ~bypass;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      offset <= 1'b0;
    end else if (core_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      offset <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (full_consume) begin
        offset <= 1'b0;
      end else if (partial) begin
        offset <= 1'b1;
      end
    end
  end

  // NOTE: entry storage has no reset; slots are never read until count marks them valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= rsp_entry;
    end
  end

endmodule
